uimac_tx_arbiter: RTL and testbench
===================================

UIMAC_TX_ARBITER -- requirements
Module: uimac_tx_arbiter

Interface
REQ-001 Parameter GRANT_TIMEOUT, default 16: cycles a granted source may take to start its frame.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles enforced after each forwarded frame.
REQ-003 I_mac_tclk  in  1  single clock; all logic on rising edge.
REQ-004 I_reset  in  1  synchronous, active-high reset.
REQ-005 I_arp_treq  in  1  ARP layer requests to send a frame; held until granted.
REQ-006 O_arp_tgrant  in/out: out  1  one-cycle grant pulse to ARP layer.
REQ-007 I_arp_tvalid  in  1  ARP frame byte valid; contiguous for the whole frame.
REQ-008 I_arp_tdata  in  8  ARP frame byte.
REQ-009 I_arp_tdest_addr  in  48  ARP destination MAC; stable from treq until frame end.
REQ-010 I_ip_treq, O_ip_tgrant, I_ip_tvalid, I_ip_tdata, I_ip_tdest_addr: same as REQ-005..009 for the IP layer.
REQ-011 I_mac_tbusy  in  1  MAC transmit busy from the MAC layer.
REQ-012 O_mac_tvalid  out  1; O_mac_tdata  out  8; O_mac_tdata_type  out  2; O_mac_tdest_addr  out  48: stream to the MAC layer.

Function
REQ-013 States: IDLE, GRANT, WAIT_START, XFER, GAP.
REQ-014 IDLE: when I_mac_tbusy=0 and at least one treq=1, select a source, go to GRANT; otherwise stay.
REQ-015 Selection: only one requesting -> that one; both requesting -> the source not served last (round robin); after reset, ARP counts as served last, so IP wins the first tie.
REQ-016 GRANT: assert the selected O_*_tgrant for exactly one cycle, latch its type and dest addr, go to WAIT_START.
REQ-017 WAIT_START: selected tvalid=1 -> XFER; else count cycles; count reaching GRANT_TIMEOUT -> GAP, no output, source not marked served.
REQ-018 XFER: forward selected tvalid/tdata to O_mac_tvalid/O_mac_tdata, registered, latency exactly 1 cycle; first byte is the one that caused the WAIT_START->XFER transition.
REQ-019 XFER ends on the first cycle the selected tvalid=0; the source is marked served; go to GAP; O_mac_tvalid goes low 1 cycle later.
REQ-020 Unselected source tvalid is ignored in all states; its treq stays pending.
REQ-021 O_mac_tdata_type = TYPE_ARP (2'b01) or TYPE_IP (2'b00), held from GRANT through GAP; O_mac_tdest_addr = latched address, same hold.
REQ-022 GAP: hold O_mac_tvalid=0 for GAP_CYCLES cycles, then IDLE; a new grant still requires I_mac_tbusy=0.
REQ-023 I_mac_tbusy rising during XFER does not stop forwarding; the MAC layer buffers the frame.
REQ-024 O_mac_tdata is 8'h00 whenever O_mac_tvalid=0.
REQ-025 Timeout counter width is clog2(GRANT_TIMEOUT)+1; the counter does not wrap and clears on leaving WAIT_START.

Reset
REQ-026 While I_reset=1 at a clock edge: state IDLE; all grants, O_mac_tvalid and O_mac_tdata are 0; O_mac_tdata_type=2'b00; O_mac_tdest_addr=0; last-served=ARP; counters 0.
REQ-027 Reset during XFER truncates the frame: O_mac_tvalid=0 on the cycle after the reset edge; a frame resumes only after a new request and grant.

Structure
REQ-028 TYPE_IP, TYPE_ARP and the state encoding belong in the shared uiudp_stack package.
REQ-029 Single flat module; the optional sub-module is uimac_rr_sel (two-input round-robin selector).

Verification
REQ-030 ARP alone: treq, then 42 bytes 0x01..0x2A -> one tgrant pulse; O_mac_tvalid for 42 cycles, starting 1 cycle after the first input byte; type 01; dest latched.
REQ-031 Both request in the same cycle after reset -> IP granted first; after IP frame end + 2 gap cycles, ARP granted.
REQ-032 I_mac_tbusy=1 held with treq pending -> no grant; grant issued 1 cycle after tbusy falls.
REQ-033 IP granted, no tvalid for 16 cycles -> return to IDLE via GAP, O_mac_tvalid never asserts, IP re-granted on its next request.
REQ-034 Reset asserted on the 10th byte of a 60-byte frame -> O_mac_tvalid=0 on the next cycle; all outputs at reset values.
REQ-035 ARP tvalid toggled during an IP transfer -> output bytes are IP data only; ARP served next.

Source files
------------

// File: rtl/uiudp_stack_pkg.sv
// Shared types for the UDP/IP stack: MAC frame type codes, arbiter state
// encoding and the source identifiers used by the MAC transmit arbiter.
package uiudp_stack;

  localparam logic [1:0] TYPE_IP  = 2'b00;
  localparam logic [1:0] TYPE_ARP = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GRANT      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_XFER       = 3'd3,
    ST_GAP        = 3'd4
  } arb_state_t;

  typedef enum logic {
    SRC_IP  = 1'b0,
    SRC_ARP = 1'b1
  } tx_src_t;

  function automatic logic [1:0] src_type(input tx_src_t src);
    return (src == SRC_ARP) ? TYPE_ARP : TYPE_IP;
  endfunction

endpackage

// File: rtl/uimac_rr_sel.sv
// Two-input round-robin selector: a lone requester wins, a tie goes to the
// source that was not served last.
module uimac_rr_sel
  import uiudp_stack::*;
(
  input  logic    arp_req,
  input  logic    ip_req,
  input  tx_src_t last_served,
  output logic    any_req,
  output tx_src_t pick
);

  always_comb begin
    any_req = arp_req | ip_req;
    pick    = SRC_IP;
    if (arp_req && (!ip_req || (last_served == SRC_IP))) begin
      pick = SRC_ARP;
    end
  end

endmodule

// File: rtl/uimac_tx_arbiter.sv
// Arbitrates ARP and IP transmit frames onto the single MAC transmit stream,
// forwarding the granted frame with one cycle of latency and a fixed idle gap.
module uimac_tx_arbiter
  import uiudp_stack::*;
#(
  parameter int GRANT_TIMEOUT = 16,
  parameter int GAP_CYCLES    = 2
) (
  input  logic        I_mac_tclk,
  input  logic        I_reset,
  input  logic        I_arp_treq,
  output logic        O_arp_tgrant,
  input  logic        I_arp_tvalid,
  input  logic [7:0]  I_arp_tdata,
  input  logic [47:0] I_arp_tdest_addr,
  input  logic        I_ip_treq,
  output logic        O_ip_tgrant,
  input  logic        I_ip_tvalid,
  input  logic [7:0]  I_ip_tdata,
  input  logic [47:0] I_ip_tdest_addr,
  input  logic        I_mac_tbusy,
  output logic        O_mac_tvalid,
  output logic [7:0]  O_mac_tdata,
  output logic [1:0]  O_mac_tdata_type,
  output logic [47:0] O_mac_tdest_addr,
  output arb_state_t  O_dbg_state
);

  // Handshake: a source raises treq and holds it (with a stable destination)
  // until it sees a one-cycle tgrant; it then drives tvalid contiguously for
  // the whole frame and ends the frame by dropping tvalid. There is no
  // back-pressure once a frame has started.

  localparam int TO_W  = $clog2(GRANT_TIMEOUT) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(GRANT_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_t       state;
  tx_src_t          sel;
  tx_src_t          last_served;
  tx_src_t          pick;
  logic             any_req;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             sel_tvalid;
  logic [7:0]       sel_tdata;
  logic [47:0]      pick_dest;

  uimac_rr_sel u_rr_sel (
    .arp_req     (I_arp_treq),
    .ip_req      (I_ip_treq),
    .last_served (last_served),
    .any_req     (any_req),
    .pick        (pick)
  );

  // The unselected source is never looked at, so its tvalid cannot leak out.
  always_comb begin
    sel_tvalid = (sel == SRC_ARP) ? I_arp_tvalid : I_ip_tvalid;
    sel_tdata  = (sel == SRC_ARP) ? I_arp_tdata  : I_ip_tdata;
    pick_dest  = (pick == SRC_ARP) ? I_arp_tdest_addr : I_ip_tdest_addr;
  end

  always_ff @(posedge I_mac_tclk) begin
    if (I_reset) begin
      state            <= ST_IDLE;
      sel              <= SRC_IP;
      last_served      <= SRC_ARP;
      to_cnt           <= '0;
      gap_cnt          <= '0;
      O_arp_tgrant     <= 1'b0;
      O_ip_tgrant      <= 1'b0;
      O_mac_tvalid     <= 1'b0;
      O_mac_tdata      <= 8'h00;
      O_mac_tdata_type <= TYPE_IP;
      O_mac_tdest_addr <= 48'h0;
    end else begin
      // Grants are pulses and data is zero unless a byte is being forwarded.
      O_arp_tgrant <= 1'b0;
      O_ip_tgrant  <= 1'b0;
      O_mac_tvalid <= 1'b0;
      O_mac_tdata  <= 8'h00;

      case (state)
        ST_IDLE: begin
          if (!I_mac_tbusy && any_req) begin
            sel              <= pick;
            state            <= ST_GRANT;
            O_arp_tgrant     <= (pick == SRC_ARP);
            O_ip_tgrant      <= (pick == SRC_IP);
            O_mac_tdata_type <= src_type(pick);
            O_mac_tdest_addr <= pick_dest;
          end
        end

        ST_GRANT: begin
          state  <= ST_WAIT_START;
          to_cnt <= '0;
        end

        ST_WAIT_START: begin
          if (sel_tvalid) begin
            state        <= ST_XFER;
            to_cnt       <= '0;
            O_mac_tvalid <= 1'b1;
            O_mac_tdata  <= sel_tdata;
          end else if (to_cnt == TO_LAST) begin
            // Abandoned grant: the source keeps its round-robin standing.
            state   <= ST_GAP;
            to_cnt  <= '0;
            gap_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ST_XFER: begin
          if (sel_tvalid) begin
            O_mac_tvalid <= 1'b1;
            O_mac_tdata  <= sel_tdata;
          end else begin
            last_served <= sel;
            state       <= ST_GAP;
            gap_cnt     <= '0;
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign O_dbg_state = state;

endmodule

// File: tb/tb_uimac_tx_arbiter.sv
// Bench for uimac_tx_arbiter: behavioural ARP/IP sources, a byte scoreboard
// and grant-rule checks, driven by directed scenarios then random traffic.
module tb_uimac_tx_arbiter;
  import uiudp_stack::*;

  localparam int GT   = 16;
  localparam int GAPC = 2;

  localparam int P_IDLE  = 0;
  localparam int P_REQ   = 1;
  localparam int P_WAIT  = 2;
  localparam int P_SEND  = 3;
  localparam int P_BLOCK = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        I_reset = 1'b1;
  logic        I_arp_treq = 1'b0, I_arp_tvalid = 1'b0;
  logic [7:0]  I_arp_tdata = 8'h00;
  logic [47:0] I_arp_tdest_addr = 48'h0;
  logic        I_ip_treq = 1'b0, I_ip_tvalid = 1'b0;
  logic [7:0]  I_ip_tdata = 8'h00;
  logic [47:0] I_ip_tdest_addr = 48'h0;
  logic        I_mac_tbusy = 1'b0;
  logic        O_arp_tgrant, O_ip_tgrant, O_mac_tvalid;
  logic [7:0]  O_mac_tdata;
  logic [1:0]  O_mac_tdata_type;
  logic [47:0] O_mac_tdest_addr;
  arb_state_t  O_dbg_state;

  uimac_tx_arbiter #(.GRANT_TIMEOUT(GT), .GAP_CYCLES(GAPC)) dut (
    .I_mac_tclk       (clk),
    .I_reset          (I_reset),
    .I_arp_treq       (I_arp_treq),
    .O_arp_tgrant     (O_arp_tgrant),
    .I_arp_tvalid     (I_arp_tvalid),
    .I_arp_tdata      (I_arp_tdata),
    .I_arp_tdest_addr (I_arp_tdest_addr),
    .I_ip_treq        (I_ip_treq),
    .O_ip_tgrant      (O_ip_tgrant),
    .I_ip_tvalid      (I_ip_tvalid),
    .I_ip_tdata       (I_ip_tdata),
    .I_ip_tdest_addr  (I_ip_tdest_addr),
    .I_mac_tbusy      (I_mac_tbusy),
    .O_mac_tvalid     (O_mac_tvalid),
    .O_mac_tdata      (O_mac_tdata),
    .O_mac_tdata_type (O_mac_tdata_type),
    .O_mac_tdest_addr (O_mac_tdest_addr),
    .O_dbg_state      (O_dbg_state)
  );

  // scoreboard: {type, dest, byte} expected on the output one cycle later
  logic [57:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  // source models, index 0 = IP, 1 = ARP
  int          phase[2]     = '{P_IDLE, P_IDLE};
  int          len[2]       = '{0, 0};
  int          sent[2]      = '{0, 0};
  int          delay[2]     = '{0, 0};
  int          start_cnt[2] = '{0, 0};
  int          block_cnt[2] = '{0, 0};
  bit          nosend[2]    = '{1'b0, 1'b0};
  bit          noise[2]     = '{1'b0, 1'b0};
  bit          ramp[2]      = '{1'b0, 1'b0};
  logic [47:0] dest[2]      = '{48'h0, 48'h0};
  int          grants[2]    = '{0, 0};
  logic        prev_g[2]    = '{1'b0, 1'b0};

  // arbiter-level model
  int model_last      = 1;
  bit frame_busy      = 1'b0;
  int hold_cnt        = 0;
  bit gap_track       = 1'b0;
  int low_since_end   = 0;
  int last_grant_low  = 0;
  int out_bytes       = 0;
  int rst_on_byte     = 0;
  bit rst_drv         = 1'b1;
  bit busy_drv        = 1'b0;

  function automatic logic [1:0] type_of(input int s);
    return (s == 1) ? 2'b01 : 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int s = 0; s < 2; s++) begin
      phase[s]  = P_IDLE;
      prev_g[s] = 1'b0;
    end
    model_last = 1;
    frame_busy = 1'b0;
    hold_cnt   = 0;
    gap_track  = 1'b0;
  endtask

  task automatic request(input int s, input int l, input int d, input bit ns, input bit nz, input bit rp);
    if (phase[s] == P_IDLE) begin
      phase[s]  = P_REQ;
      len[s]    = l;
      delay[s]  = d;
      nosend[s] = ns;
      noise[s]  = nz;
      ramp[s]   = rp;
      dest[s]   = {16'($urandom), 32'($urandom)};
    end
  endtask

  // driver: sets every DUT input for the coming cycle
  task automatic drive();
    logic       v[2];
    logic [7:0] d[2];
    for (int s = 0; s < 2; s++) begin
      v[s] = 1'b0;
      d[s] = 8'($urandom);
      if (phase[s] == P_BLOCK) begin
        if (block_cnt[s] > 0) block_cnt[s]--;
        else phase[s] = P_IDLE;
      end
      if (phase[s] == P_REQ && noise[s]) v[s] = 1'($urandom_range(0, 1));
      if (phase[s] == P_WAIT) begin
        if (start_cnt[s] == 0) phase[s] = P_SEND;
        else start_cnt[s]--;
      end
      if (phase[s] == P_SEND) begin
        if (sent[s] < len[s]) begin
          v[s] = 1'b1;
          if (ramp[s]) d[s] = 8'(sent[s] + 1);
          sent[s]++;
          exp_q.push_back({type_of(s), dest[s], d[s]});
          if (rst_on_byte != 0 && sent[s] == rst_on_byte) begin
            rst_drv     = 1'b1;
            rst_on_byte = 0;
          end
        end else begin
          phase[s]      = P_IDLE;
          frame_busy    = 1'b0;
          model_last    = s;
          gap_track     = 1'b1;
          low_since_end = 0;
        end
      end
    end
    I_reset          = rst_drv;
    I_mac_tbusy      = busy_drv;
    I_ip_treq        = (phase[0] == P_REQ);
    I_ip_tvalid      = v[0];
    I_ip_tdata       = d[0];
    I_ip_tdest_addr  = dest[0];
    I_arp_treq       = (phase[1] == P_REQ);
    I_arp_tvalid     = v[1];
    I_arp_tdata      = d[1];
    I_arp_tdest_addr = dest[1];
  endtask

  // one clock: drive, edge, then check outputs against the model
  task automatic step();
    bit   req_s[2];
    bit   busy_s, rst_s;
    logic g[2];
    int   winner;
    logic [57:0] e;
    drive();
    req_s[0] = I_ip_treq;
    req_s[1] = I_arp_treq;
    busy_s   = I_mac_tbusy;
    rst_s    = I_reset;
    @(posedge clk);
    #1;
    if (rst_s) begin
      chk("rst_outputs", {O_arp_tgrant, O_ip_tgrant, O_mac_tvalid, O_mac_tdata,
                          O_mac_tdata_type, O_mac_tdest_addr}, 64'h0);
      chk("rst_state", O_dbg_state, ST_IDLE);
      model_reset();
      return;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_valid", O_mac_tvalid, 1);
      chk("out_beat", {O_mac_tdata_type, O_mac_tdest_addr, O_mac_tdata}, e);
      out_bytes++;
    end else begin
      chk("out_idle", O_mac_tvalid, 0);
      chk("idle_data_zero", O_mac_tdata, 0);
    end
    g[0] = O_ip_tgrant;
    g[1] = O_arp_tgrant;
    chk("dual_grant", g[0] & g[1], 0);
    if (req_s[0] && req_s[1]) winner = 1 - model_last;
    else if (req_s[1]) winner = 1;
    else winner = 0;
    for (int s = 0; s < 2; s++) begin
      chk("grant_pulse", g[s] & prev_g[s], 0);
      prev_g[s] = g[s];
      if (g[s]) begin
        grants[s]++;
        chk("grant_req", req_s[s], 1);
        chk("grant_busy", busy_s, 0);
        chk("grant_rr", s, winner);
        chk("grant_overlap", {frame_busy, hold_cnt > 0}, 0);
        chk("grant_type", O_mac_tdata_type, type_of(s));
        chk("grant_dest", O_mac_tdest_addr, dest[s]);
        if (gap_track) chk("grant_gap", low_since_end >= GAPC, 1);
        last_grant_low = low_since_end;
        gap_track = 1'b0;
        if (nosend[s]) begin
          phase[s]     = P_BLOCK;
          block_cnt[s] = GT + 6;
          hold_cnt     = GT;
        end else begin
          phase[s]     = P_WAIT;
          start_cnt[s] = delay[s] + 1;
          sent[s]      = 0;
          frame_busy   = 1'b1;
        end
      end
    end
    if (hold_cnt > 0) hold_cnt--;
    if (!O_mac_tvalid) low_since_end++;
  endtask

  function automatic bit model_idle();
    return phase[0] == P_IDLE && phase[1] == P_IDLE && !frame_busy &&
           hold_cnt == 0 && exp_q.size() == 0;
  endfunction

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!model_idle() && n < budget) begin
      step();
      n++;
    end
    chk(tag, model_idle(), 1);
  endtask

  task automatic wait_grant(input int s, input int budget, input string tag);
    int g0 = grants[s];
    int n = 0;
    while (grants[s] == g0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, grants[s] - g0, 1);
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    repeat (3) step();
    rst_drv = 1'b0;
    step();
  endtask

  initial begin
    int g0, g1, ob, n;

    do_reset();
    chk("reset_type", O_mac_tdata_type, 2'b00);

    // ARP alone, 42 ramp bytes
    g0 = grants[1];
    ob = out_bytes;
    request(1, 42, 0, 1'b0, 1'b0, 1'b1);
    wait_idle(200, "arp_frame_done");
    chk("arp_grant_count", grants[1] - g0, 1);
    chk("arp_byte_count", out_bytes - ob, 42);
    step();
    chk("type_held", O_mac_tdata_type, 2'b01);
    chk("dest_held", O_mac_tdest_addr, dest[1]);

    // simultaneous requests after reset: IP first, ARP after the gap
    do_reset();
    g1 = grants[1];
    request(0, 20, 1, 1'b0, 1'b0, 1'b0);
    request(1, 10, 0, 1'b0, 1'b0, 1'b0);
    wait_grant(0, 10, "tie_ip_grant");
    chk("tie_arp_not_yet", grants[1] - g1, 0);
    wait_grant(1, 100, "tie_arp_grant");
    chk("arp_after_gap", last_grant_low, GAPC + 1);
    wait_idle(100, "tie_done");

    // busy holds off the grant; grant follows one cycle after busy drops
    busy_drv = 1'b1;
    g1 = grants[1];
    request(1, 6, 0, 1'b0, 1'b0, 1'b0);
    repeat (10) step();
    chk("busy_no_grant", grants[1] - g1, 0);
    busy_drv = 1'b0;
    step();
    chk("grant_after_busy", grants[1] - g1, 1);
    wait_idle(100, "busy_done");

    // IP granted but never starts: timeout, then re-grant on a new request
    ob = out_bytes;
    request(0, 5, 0, 1'b1, 1'b0, 1'b0);
    wait_grant(0, 10, "to_grant");
    repeat (GT + 8) step();
    chk("to_no_output", out_bytes - ob, 0);
    chk("to_state_idle", O_dbg_state, ST_IDLE);
    request(0, 8, 1, 1'b0, 1'b0, 1'b0);
    wait_grant(0, 30, "to_regrant");
    wait_idle(100, "to_done");

    // reset on the 10th byte of a 60-byte frame
    ob = out_bytes;
    request(0, 60, 0, 1'b0, 1'b0, 1'b0);
    rst_on_byte = 10;
    wait_grant(0, 10, "rst_grant");
    n = 0;
    while (!rst_drv && n < 100) begin
      step();
      n++;
    end
    chk("rst_hit", rst_drv, 1);
    rst_drv = 1'b0;
    chk("rst_trunc_bytes", out_bytes - ob, 9);
    repeat (5) step();
    chk("rst_no_resume", out_bytes - ob, 9);
    request(0, 5, 0, 1'b0, 1'b0, 1'b0);
    wait_grant(0, 10, "rst_regrant");
    wait_idle(100, "rst_done");

    // ARP toggles tvalid during an IP frame; ARP served next
    request(0, 30, 2, 1'b0, 1'b0, 1'b0);
    wait_grant(0, 10, "noise_ip_grant");
    request(1, 12, 0, 1'b0, 1'b1, 1'b0);
    wait_grant(1, 200, "noise_arp_next");
    wait_idle(200, "noise_done");

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      for (int s = 0; s < 2; s++) begin
        if (phase[s] == P_IDLE && $urandom_range(0, 9) == 0)
          request(s, $urandom_range(1, 24), $urandom_range(0, GT - 3),
                  ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 1'b0);
      end
      if ($urandom_range(0, 15) == 0) busy_drv = ~busy_drv;
      step();
    end
    busy_drv = 1'b0;
    wait_idle(2000, "random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
